axi4_fifo_master: RTL and testbench

Bridges the memory-side command/data FIFO streams from the platform core onto a single AXI4 master port feeding the DDR3 controller. Consumes 65-bit read/write commands, splits each into AXI4 INCR bursts and streams write data from, or read data into, 32-bit FIFO streams. Sits between the core's `mem_cmd`/`mem_write`/`mem_read` streams and the `AXI4_Std` master in the board wrapper, clocked by the memory UI clock.

---
 rtl/axi4_fifo_master_pkg.sv | 26 ++
 rtl/axi4_burst_calc.sv | 31 +++
 rtl/axi4_fifo_master.sv | 186 ++++++++++++++++++
 tb/tb_axi4_fifo_master.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_fifo_master_pkg.sv
// Shared types and AXI constants for the FIFO-to-AXI4 master bridge.
package axi4_fifo_master_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA
   } state_t;

   // Layout matches the 65-bit command word: [64] rnw, [63:32] word address, [31:0] word count.
   typedef struct packed {
      logic        rnw;
      logic [31:0] addr;
      logic [31:0] count;
   } mem_cmd_t;

   localparam int         ID_W          = 4;
   localparam logic [2:0] SIZE_4B       = 3'b010;
   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic [1:0] RESP_OKAY     = 2'b00;

endpackage

// File: rtl/axi4_burst_calc.sv
// Beats in the next burst: min(remaining, max_burst) and, with
// AXI4_FIFO_MASTER_4K_SPLIT_EN defined, no crossing of a 4 KB byte boundary.
module axi4_burst_calc #(
   parameter int max_burst = 16
) (
   input  logic [31:0] addr,
   input  logic [31:0] remaining,
   output logic [8:0]  beats
);

   logic [31:0] lim;
   logic        unused_addr;

`ifdef AXI4_FIFO_MASTER_4K_SPLIT_EN
   // Word address bits [9:0] locate the word within its 4 KB page.
   logic [31:0] to_page_end;
   assign to_page_end = 32'd1024 - {22'd0, addr[9:0]};
   assign unused_addr = ^addr[31:10];
`else
   assign unused_addr = ^addr;
`endif

   always_comb begin
      lim = (remaining < 32'(max_burst)) ? remaining : 32'(max_burst);
`ifdef AXI4_FIFO_MASTER_4K_SPLIT_EN
      if (to_page_end < lim) lim = to_page_end;
`endif
      beats = lim[8:0];
   end

endmodule

// File: rtl/axi4_fifo_master.sv
// Bridges mem_cmd/mem_write/mem_read FIFO streams onto one AXI4 master port.
// Optional AXI4_FIFO_MASTER_4K_SPLIT_EN keeps bursts inside 4 KB pages.
module axi4_fifo_master
   import axi4_fifo_master_pkg::*;
#(
   parameter int mem_width = 32,
   parameter int max_burst = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   mig_init_done,
   input  logic [64:0]            ext_mem_cmd_data,
   input  logic                   ext_mem_cmd_valid,
   output logic                   ext_mem_cmd_ready,
   input  logic [mem_width-1:0]   ext_mem_write_data,
   input  logic                   ext_mem_write_valid,
   output logic                   ext_mem_write_ready,
   output logic [mem_width-1:0]   ext_mem_read_data,
   output logic                   ext_mem_read_valid,
   input  logic                   ext_mem_read_ready,
   output logic [ID_W-1:0]        axi_awid,
   output logic [31:0]            axi_awaddr,
   output logic [7:0]             axi_awlen,
   output logic [2:0]             axi_awsize,
   output logic [1:0]             axi_awburst,
   output logic                   axi_awlock,
   output logic [3:0]             axi_awcache,
   output logic [2:0]             axi_awprot,
   output logic [3:0]             axi_awqos,
   output logic                   axi_awvalid,
   input  logic                   axi_awready,
   output logic [mem_width-1:0]   axi_wdata,
   output logic [mem_width/8-1:0] axi_wstrb,
   output logic                   axi_wlast,
   output logic                   axi_wvalid,
   input  logic                   axi_wready,
   input  logic [ID_W-1:0]        axi_bid,
   input  logic [1:0]             axi_bresp,
   input  logic                   axi_bvalid,
   output logic                   axi_bready,
   output logic [ID_W-1:0]        axi_arid,
   output logic [31:0]            axi_araddr,
   output logic [7:0]             axi_arlen,
   output logic [2:0]             axi_arsize,
   output logic [1:0]             axi_arburst,
   output logic                   axi_arlock,
   output logic [3:0]             axi_arcache,
   output logic [2:0]             axi_arprot,
   output logic [3:0]             axi_arqos,
   output logic                   axi_arvalid,
   input  logic                   axi_arready,
   input  logic [ID_W-1:0]        axi_rid,
   input  logic [mem_width-1:0]   axi_rdata,
   input  logic [1:0]             axi_rresp,
   input  logic                   axi_rlast,
   input  logic                   axi_rvalid,
   output logic                   axi_rready,
   output logic                   error
);

   state_t      state, state_nx;
   mem_cmd_t    cmd;
   logic [31:0] addr_q, rem_q;
   logic [8:0]  beat_q, beats, len9;
   logic        last_beat, done, unused_ok;

   assign cmd = ext_mem_cmd_data;

   // addr_q/rem_q only move on a response, so beats and len hold for the whole burst.
   axi4_burst_calc #(.max_burst(max_burst)) u_calc (
      .addr      (addr_q),
      .remaining (rem_q),
      .beats     (beats)
   );

   assign len9      = beats - 9'd1;
   assign last_beat = (beat_q == len9);
   assign done      = (rem_q == {23'd0, beats});
   assign unused_ok = ^{addr_q[31:30], len9[8], axi_bid, axi_rid};

   assign axi_awid    = '0;
   assign axi_awaddr  = {addr_q[29:0], 2'b00};
   assign axi_awlen   = len9[7:0];
   assign axi_awsize  = SIZE_4B;
   assign axi_awburst = BURST_INCR;
   assign axi_awlock  = 1'b0;
   assign axi_awcache = CACHE_DEFAULT;
   assign axi_awprot  = '0;
   assign axi_awqos   = '0;
   assign axi_arid    = '0;
   assign axi_araddr  = {addr_q[29:0], 2'b00};
   assign axi_arlen   = len9[7:0];
   assign axi_arsize  = SIZE_4B;
   assign axi_arburst = BURST_INCR;
   assign axi_arlock  = 1'b0;
   assign axi_arcache = CACHE_DEFAULT;
   assign axi_arprot  = '0;
   assign axi_arqos   = '0;

   assign axi_wdata         = ext_mem_write_data;
   assign axi_wstrb         = '1;
   assign axi_wlast         = (state == WR_DATA) && last_beat;
   assign ext_mem_read_data = axi_rdata;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx            = state;
      ext_mem_cmd_ready   = 1'b0;
      ext_mem_write_ready = 1'b0;
      ext_mem_read_valid  = 1'b0;
      axi_awvalid         = 1'b0;
      axi_wvalid          = 1'b0;
      axi_bready          = 1'b0;
      axi_arvalid         = 1'b0;
      axi_rready          = 1'b0;
      case (state)
         IDLE: begin
            ext_mem_cmd_ready = mig_init_done && !reset;
            if (mig_init_done && ext_mem_cmd_valid && cmd.count != 32'd0)
               state_nx = cmd.rnw ? RD_ADDR : WR_ADDR;
         end
         WR_ADDR: begin
            axi_awvalid = 1'b1;
            if (axi_awready) state_nx = WR_DATA;
         end
         WR_DATA: begin
            axi_wvalid          = ext_mem_write_valid;
            ext_mem_write_ready = axi_wready;
            if (ext_mem_write_valid && axi_wready && last_beat) state_nx = WR_RESP;
         end
         WR_RESP: begin
            axi_bready = 1'b1;
            if (axi_bvalid) state_nx = done ? IDLE : WR_ADDR;
         end
         RD_ADDR: begin
            axi_arvalid = 1'b1;
            if (axi_arready) state_nx = RD_DATA;
         end
         RD_DATA: begin
            ext_mem_read_valid = axi_rvalid;
            axi_rready         = ext_mem_read_ready;
            if (axi_rvalid && ext_mem_read_ready && axi_rlast) state_nx = done ? IDLE : RD_ADDR;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr_q <= '0;
         rem_q  <= '0;
         beat_q <= '0;
         error  <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (ext_mem_cmd_ready && ext_mem_cmd_valid) begin
                  addr_q <= cmd.addr;
                  rem_q  <= cmd.count;
               end
            WR_ADDR: beat_q <= '0;
            WR_DATA:
               if (ext_mem_write_valid && axi_wready) beat_q <= beat_q + 9'd1;
            WR_RESP:
               if (axi_bvalid) begin
                  addr_q <= addr_q + {23'd0, beats};
                  rem_q  <= rem_q - {23'd0, beats};
               end
            RD_DATA:
               if (axi_rvalid && ext_mem_read_ready && axi_rlast) begin
                  addr_q <= addr_q + {23'd0, beats};
                  rem_q  <= rem_q - {23'd0, beats};
               end
            default: ;
         endcase
         if ((axi_bvalid && axi_bready && axi_bresp != RESP_OKAY) ||
             (axi_rvalid && axi_rready && axi_rresp != RESP_OKAY))
            error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_axi4_fifo_master.sv
// Randomized bench: a behavioural AXI slave plus a command-level model of bursts and memory.
module tb_axi4_fifo_master;

   localparam int MB = 16;

   logic        clk = 0, reset = 1, mig_init_done = 0;
   logic [64:0] ext_mem_cmd_data = '0;
   logic        ext_mem_cmd_valid = 0, ext_mem_cmd_ready;
   logic [31:0] ext_mem_write_data = '0, ext_mem_read_data;
   logic        ext_mem_write_valid = 0, ext_mem_write_ready;
   logic        ext_mem_read_valid, ext_mem_read_ready = 0;
   logic [3:0]  axi_awid, axi_arid, axi_awcache, axi_arcache, axi_awqos, axi_arqos, axi_wstrb;
   logic [3:0]  axi_bid = '0, axi_rid = '0;
   logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata = '0;
   logic [7:0]  axi_awlen, axi_arlen;
   logic [2:0]  axi_awsize, axi_arsize, axi_awprot, axi_arprot;
   logic [1:0]  axi_awburst, axi_arburst, axi_bresp = '0, axi_rresp = '0;
   logic        axi_awlock, axi_arlock, axi_awvalid, axi_arvalid, axi_wvalid, axi_wlast;
   logic        axi_awready = 0, axi_arready = 0, axi_wready = 0, axi_bvalid = 0, axi_bready;
   logic        axi_rvalid = 0, axi_rlast = 0, axi_rready, error;

   always #5 clk = ~clk;

   axi4_fifo_master #(.mem_width(32), .max_burst(MB)) dut (
      .clk(clk), .reset(reset), .mig_init_done(mig_init_done),
      .ext_mem_cmd_data(ext_mem_cmd_data), .ext_mem_cmd_valid(ext_mem_cmd_valid),
      .ext_mem_cmd_ready(ext_mem_cmd_ready),
      .ext_mem_write_data(ext_mem_write_data), .ext_mem_write_valid(ext_mem_write_valid),
      .ext_mem_write_ready(ext_mem_write_ready),
      .ext_mem_read_data(ext_mem_read_data), .ext_mem_read_valid(ext_mem_read_valid),
      .ext_mem_read_ready(ext_mem_read_ready),
      .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
      .axi_awburst(axi_awburst), .axi_awlock(axi_awlock), .axi_awcache(axi_awcache),
      .axi_awprot(axi_awprot), .axi_awqos(axi_awqos), .axi_awvalid(axi_awvalid),
      .axi_awready(axi_awready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
      .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst), .axi_arlock(axi_arlock), .axi_arcache(axi_arcache),
      .axi_arprot(axi_arprot), .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid),
      .axi_arready(axi_arready),
      .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .error(error)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { bit rnw; logic [31:0] baddr; logic [7:0] len; } burst_t;
   burst_t      exp_q[$];
   logic [31:0] wq[$], exp_rd[$];
   logic [31:0] mem[int unsigned], ref_mem[int unsigned];

   function automatic logic [31:0] dflt(input int unsigned a);
      return a ^ 32'h5a5a_0000;
   endfunction

   function automatic logic [31:0] ref_rd(input int unsigned a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [31:0] mem_rd(input int unsigned a);
      return mem.exists(a) ? mem[a] : dflt(a);
   endfunction

   function automatic int unsigned model_beats(input int unsigned wa, input int unsigned rem);
      int unsigned b;
      b = (rem < MB) ? rem : MB;
`ifdef AXI4_FIFO_MASTER_4K_SPLIT_EN
      if (1024 - (wa % 1024) < b) b = 1024 - (wa % 1024);
`endif
      return b;
   endfunction

   function automatic bit rnd();
      return $urandom_range(0, 3) != 0;
   endfunction

   // ---------------- AXI slave / FIFO endpoints ----------------
   bit          in_rst = 1, err_inj = 0, err_exp = 0, rr_toggle = 0;
   bit          w_act = 0, b_pend = 0, r_act = 0, b_hold = 0, r_hold = 0, aw_due = 0, ar_due = 0;
   int unsigned w_wa = 0, r_wa = 0;
   int          w_len = 0, w_idx = 0, r_len = 0, r_idx = 0, cyc = 0;

   task automatic eval();
      chk("error", error, err_exp);
      if (aw_due) chk("aw_after_b", axi_awvalid, 1);
      if (ar_due) chk("ar_after_rlast", axi_arvalid, 1);
      aw_due = 0;
      ar_due = 0;
      // B before W and R before AR so each sees the phase the DUT is in this cycle
      chk("bready", axi_bready, b_pend);
      if (axi_bvalid && axi_bready) begin
         if (axi_bresp != 2'b00) err_exp = 1;
         b_pend = 0;
         aw_due = exp_q.size() > 0;
      end
      b_hold = axi_bvalid && !axi_bready;
      chk("wvalid", axi_wvalid, w_act && ext_mem_write_valid);
      chk("write_ready", ext_mem_write_ready, w_act && axi_wready);
      if (w_act && axi_wvalid && axi_wready) begin
         if (wq.size() > 0) begin
            chk("wdata", axi_wdata, wq[0]);
            void'(wq.pop_front());
         end else chk("w_extra_beat", 1, 0);
         chk("wlast", axi_wlast, w_idx == w_len);
         chk("wstrb", axi_wstrb, 4'hf);
         mem[w_wa + w_idx] = axi_wdata;
         w_idx++;
         if (w_idx > w_len) begin
            w_act  = 0;
            b_pend = 1;
         end
      end
      chk("rready", axi_rready, r_act && ext_mem_read_ready);
      chk("read_valid", ext_mem_read_valid, axi_rvalid);
      if (axi_rvalid && axi_rready) begin
         if (exp_rd.size() > 0) chk("read_data", ext_mem_read_data, exp_rd.pop_front());
         else chk("r_extra_beat", 1, 0);
         r_idx++;
         if (axi_rlast) begin
            r_act  = 0;
            ar_due = exp_q.size() > 0;
         end
      end
      r_hold = axi_rvalid && !axi_rready;
      if (axi_awvalid) begin
         chk("aw_expected", exp_q.size() > 0 && !exp_q[0].rnw, 1);
         if (axi_awready && exp_q.size() > 0) begin
            chk("awaddr", axi_awaddr, exp_q[0].baddr);
            chk("awlen", axi_awlen, exp_q[0].len);
            chk("aw_const", {axi_awid, axi_awsize, axi_awburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos},
                {4'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
            w_act = 1; w_wa = axi_awaddr >> 2; w_len = int'(axi_awlen); w_idx = 0;
            void'(exp_q.pop_front());
         end
      end
      if (axi_arvalid) begin
         chk("ar_expected", exp_q.size() > 0 && exp_q[0].rnw, 1);
         if (axi_arready && exp_q.size() > 0) begin
            chk("araddr", axi_araddr, exp_q[0].baddr);
            chk("arlen", axi_arlen, exp_q[0].len);
            chk("ar_const", {axi_arid, axi_arsize, axi_arburst, axi_arlock, axi_arcache, axi_arprot, axi_arqos},
                {4'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
            r_act = 1; r_wa = axi_araddr >> 2; r_len = int'(axi_arlen); r_idx = 0;
            void'(exp_q.pop_front());
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (in_rst) begin
            {axi_awready, axi_arready, axi_wready, ext_mem_write_valid, ext_mem_read_ready} = '0;
            {axi_bvalid, axi_rvalid, axi_rlast} = '0;
            axi_bresp = '0; axi_rdata = '0;
            {w_act, b_pend, r_act, b_hold, r_hold, aw_due, ar_due} = '0;
            exp_q.delete(); wq.delete(); exp_rd.delete();
         end else begin
            axi_awready         = rnd();
            axi_arready         = rnd();
            axi_wready          = rnd();
            ext_mem_write_valid = (wq.size() > 0) && rnd();
            ext_mem_write_data  = (wq.size() > 0) ? wq[0] : $urandom;
            ext_mem_read_ready  = rr_toggle ? cyc[0] : rnd();
            axi_bvalid          = b_pend && (b_hold || rnd());
            axi_bresp           = err_inj ? 2'b10 : 2'b00;
            axi_rvalid          = r_act && (r_hold || rnd());
            axi_rdata           = r_act ? mem_rd(r_wa + r_idx) : 32'd0;
            axi_rlast           = r_act && (r_idx == r_len);
            #1;
            eval();
         end
      end
   end

   // ---------------- command side ----------------
   task automatic issue(input bit rnw, input logic [31:0] wa, input logic [31:0] cnt, input int hold = 0);
      int unsigned a, rem, b;
      int          n;
      bit          hs;
      logic [31:0] w;
      a = wa; rem = cnt; n = 0; hs = 0;
      while (rem > 0) begin
         b = model_beats(a, rem);
         exp_q.push_back('{rnw, 32'(a << 2), 8'(b - 1)});
         a += b;
         rem -= b;
      end
      for (int i = 0; i < int'(cnt); i++) begin
         if (!rnw) begin
            w = $urandom;
            wq.push_back(w);
            ref_mem[wa + i] = w;
         end else exp_rd.push_back(ref_rd(wa + i));
      end
      if (hold > 0) mig_init_done = 0;
      @(negedge clk);
      ext_mem_cmd_valid = 1;
      ext_mem_cmd_data  = {rnw, wa, cnt};
      if (hold > 0) begin
         repeat (hold) begin
            #1;
            chk("ready_while_uninit", ext_mem_cmd_ready, 0);
            @(negedge clk);
         end
         mig_init_done = 1;
      end
      while (!hs && n < 200) begin
         #1;
         hs = ext_mem_cmd_ready;
         if (!hs) begin
            @(negedge clk);
            n++;
         end
      end
      chk("cmd_accept", hs, 1);
      if (hold > 0) chk("accept_after_init", n, 0);
      @(negedge clk);
      ext_mem_cmd_valid = 0;
      ext_mem_cmd_data  = {1'b0, 32'hdead_beef, 32'h0};
      #1;
      chk("addr_valid_next_cycle", axi_awvalid | axi_arvalid, cnt != 0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 3000 && (exp_q.size() > 0 || wq.size() > 0 || exp_rd.size() > 0 || w_act || b_pend || r_act)) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_complete", n < 3000, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      reset = 1; in_rst = 1; err_exp = 0; ext_mem_cmd_valid = 0;
      repeat (2) @(posedge clk);
      #2;
      reset = 0; in_rst = 0;
   endtask

   bit          r_rnw;
   logic [31:0] r_addr, r_cnt;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      reset = 0; in_rst = 0;
      @(negedge clk);
      #1;
      chk("reset_outs", {ext_mem_cmd_ready, axi_awvalid, axi_arvalid, axi_wvalid, ext_mem_write_ready,
                         axi_bready, axi_rready, ext_mem_read_valid, error}, 0);

      issue(0, 32'h10, 4, 4);             // AW 0x40 len 3, held off until init done
      wait_idle();
      issue(1, 32'h0, 20);                // AR 0x0 len 15, then 0x40 len 3
      wait_idle();
      issue(0, 32'h3FC, 8);               // straddles the 4 KB line at byte 0x1000
      wait_idle();
      issue(1, 32'h3F8, 16);
      wait_idle();
      issue(0, 32'h20, 0);                // dropped, no AXI traffic expected
      wait_idle();
      issue(1, 32'h20, 0);
      repeat (5) @(negedge clk);

      rr_toggle = 1;
      issue(1, 32'h3FC, 8);
      wait_idle();
      rr_toggle = 0;

      issue(0, 32'h100, 40);
      repeat (3) @(negedge clk);
      mig_init_done = 0;                  // must not stall the command in flight
      wait_idle();
      mig_init_done = 1;
      issue(1, 32'h100, 40);
      wait_idle();

      err_inj = 1;
      issue(0, 32'h50, 3);
      wait_idle();
      err_inj = 0;
      chk("error_set", error, 1);
      issue(1, 32'h50, 3);
      wait_idle();
      chk("error_sticky", error, 1);
      do_reset();
      @(negedge clk);
      #1;
      chk("error_cleared", error, 0);

      issue(0, 32'h200, 30);
      repeat (8) @(negedge clk);
      do_reset();
      @(negedge clk);
      #1;
      chk("reset_midop", {axi_awvalid, axi_arvalid, axi_wvalid, ext_mem_write_ready,
                          axi_bready, axi_rready, ext_mem_read_valid, error}, 0);
      issue(1, 32'h400, 10);
      wait_idle();

      for (int k = 0; k < 40; k++) begin
         r_rnw  = 1'($urandom_range(0, 1));
         r_addr = (k % 4 == 0) ? 32'hBF0 + $urandom_range(0, 15) : 32'h800 + $urandom_range(0, 32'h7E0);
         r_cnt  = $urandom_range(0, 40);
         issue(r_rnw, r_addr, r_cnt);
         wait_idle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
